nibble_seq: RTL and testbench

NIBBLE_SEQ -- requirements
Module: nibble_seq

---
 rtl/nibble_seq.sv | 82 ++++++++
 tb/tb_nibble_seq.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_seq.sv
// nibble_seq: runs one W-bit operation as NIBBLES 4-bit slices through an external combinational ALU.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_op/req_a/req_b request handshake;
// resp_valid/resp_ready/resp_res/resp_carry/resp_zero/resp_eq response handshake;
// alu_d1/alu_d2/alu_ctrl drive the external ALU slice, alu_res/alu_carry_out return from it the same cycle.
module nibble_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [W-1:0] resp_res,
  output logic         resp_carry,
  output logic         resp_zero,
  output logic         resp_eq,
  output logic [3:0]   alu_d1,
  output logic [3:0]   alu_d2,
  output logic [4:0]   alu_ctrl,
  input  logic [3:0]   alu_res,
  input  logic         alu_carry_out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_COMP = 3'd4, OP_RSHFT = 3'd7;
  localparam logic [3:0] CTRL [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b1000, 4'b0101, 4'b0110, 4'b0111};
  state_t state, state_n;
  logic [2:0] op_q, idx;
  logic [W-1:0] a_q, b_q, res_q, res_n;
  logic carry_q, last, arith, cin;
  logic [5:0] sh;
  assign req_ready = state == IDLE;
  assign resp_valid = state == DONE;
  assign resp_res = res_q;
  // Right shift walks down from the top slice, so each slice's shift-in bit is the LSB of the B nibble above it;
  // beyond the top of B the shift yields 0.
  always_comb begin
    sh = {1'b0, idx, 2'b00};
    last = op_q == OP_RSHFT ? idx == 3'd0 : idx == 3'(NIBBLES - 1);
    arith = op_q == OP_ADD || op_q == OP_SUB || op_q == OP_COMP;
    cin = op_q == OP_RSHFT ? 1'(b_q >> (sh + 6'd4)) : arith ? (idx == 3'd0 ? op_q == OP_SUB : carry_q) : 1'b0;
    res_n = (res_q & ~(W'(4'hf) << sh)) | (W'(alu_res) << sh);
    state_n = state == IDLE ? (req_valid ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : (resp_ready ? IDLE : DONE);
    alu_d1 = state == RUN ? 4'(a_q >> sh) : 4'd0;
    alu_d2 = state == RUN ? 4'(b_q >> sh) : 4'd0;
    alu_ctrl = state == RUN ? {cin, CTRL[op_q]} : 5'd0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      res_q <= '0;
      carry_q <= 1'b0;
      idx <= 3'd0;
      resp_carry <= 1'b0;
      resp_zero <= 1'b0;
      resp_eq <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        op_q <= req_op;
        a_q <= req_a;
        b_q <= req_b;
        carry_q <= 1'b0;
        idx <= req_op == OP_RSHFT ? 3'(NIBBLES - 1) : 3'd0;
      end
      if (state == RUN) begin
        res_q <= res_n;
        carry_q <= alu_carry_out;
        idx <= op_q == OP_RSHFT ? idx - 3'd1 : idx + 3'd1;
        if (last) begin
          resp_carry <= arith ? alu_carry_out : op_q == OP_RSHFT && b_q[0];
          resp_zero <= res_n == '0;
          resp_eq <= op_q == OP_COMP && &res_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_seq.sv
// tb_nibble_seq: randomized and directed checking of nibble_seq against a word-level reference model.
module tb_nibble_seq;
  localparam int N = 4;
  localparam int W = 16;
  localparam logic [3:0] CTRL [8] = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b1000, 4'b0101, 4'b0110, 4'b0111};
  typedef struct {
    logic [2:0] op;
    logic [W-1:0] a, b, res;
    logic c, z, e;
  } vec_t;
  vec_t dir [12] = '{
    '{3'd0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0},
    '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0},
    '{3'd1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b0},
    '{3'd1, 16'h1000, 16'h0001, 16'h0FFF, 1'b1, 1'b0, 1'b0},
    '{3'd4, 16'h8000, 16'h7FFF, 16'h0000, 1'b1, 1'b1, 1'b0},
    '{3'd4, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b1},
    '{3'd4, 16'h0003, 16'h0005, 16'hFFFD, 1'b0, 1'b0, 1'b0},
    '{3'd7, 16'hFFFF, 16'h8421, 16'h4210, 1'b1, 1'b0, 1'b0},
    '{3'd2, 16'hF0A5, 16'h0FF0, 16'hFF55, 1'b0, 1'b0, 1'b0},
    '{3'd3, 16'hF0A5, 16'h0FF0, 16'h00AA, 1'b0, 1'b0, 1'b0},
    '{3'd5, 16'hF0A5, 16'h0FF0, 16'h00A0, 1'b0, 1'b0, 1'b0},
    '{3'd6, 16'hF0A5, 16'h0FF0, 16'hFFF5, 1'b0, 1'b0, 1'b0}
  };
  logic clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, resp_ready = 1'b0;
  logic req_ready, resp_valid, resp_carry, resp_zero, resp_eq, alu_carry_out;
  logic [2:0] req_op = 3'd0;
  logic [W-1:0] req_a = '0, req_b = '0, resp_res;
  logic [3:0] alu_d1, alu_d2, alu_res, b2;
  logic [4:0] alu_ctrl, sum;
  logic [3:0] cap_d2 [N];
  logic cap_cin [N];
  int vectors = 0, errs = 0;
  bit go = 0;
  int m_st = 0, m_k = 0;
  logic [2:0] m_op = 3'd0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic m_c = 1'b0, m_z = 1'b0, m_e = 1'b0;

  always #5 clk = ~clk;

  nibble_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_res(resp_res),
    .resp_carry(resp_carry), .resp_zero(resp_zero), .resp_eq(resp_eq),
    .alu_d1(alu_d1), .alu_d2(alu_d2), .alu_ctrl(alu_ctrl), .alu_res(alu_res), .alu_carry_out(alu_carry_out)
  );

  // Stand-in slice ALU; logic ops report carry 1 so the block must mask it.
  always_comb begin
    b2 = alu_ctrl[3] ? ~alu_d2 : alu_d2;
    sum = {1'b0, alu_d1} + {1'b0, b2} + {4'b0, alu_ctrl[4]};
    case (alu_ctrl[1:0])
      2'd0: {alu_carry_out, alu_res} = alu_ctrl[2] ? {1'b1, alu_d1 ^ b2} : sum;
      2'd1: {alu_carry_out, alu_res} = {1'b1, alu_d1 & b2};
      2'd2: {alu_carry_out, alu_res} = {1'b1, alu_d1 | b2};
      default: {alu_carry_out, alu_res} = {alu_d2[0], alu_ctrl[4], alu_d2[3:1]};
    endcase
  end

  function automatic logic [W:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {a >= b, W'(a - b)};
      3'd2: return {1'b0, a ^ b};
      3'd3: return {1'b0, ~(a ^ b)};
      3'd4: return {a > b, W'(a - b - 1)};
      3'd5: return {1'b0, a & b};
      3'd6: return {1'b0, a | b};
      default: return {b[0], b >> 1};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: idle / N slice cycles / done, result from plain arithmetic.
  always @(posedge clk) begin
    logic [W:0] r;
    if (!rst_n) begin
      m_st <= 0;
      m_res <= '0;
      m_c <= 1'b0;
      m_z <= 1'b0;
      m_e <= 1'b0;
    end else if (m_st == 0) begin
      if (req_valid) begin
        m_st <= 1;
        m_k <= 0;
        m_op <= req_op;
        m_a <= req_a;
        m_b <= req_b;
      end
    end else if (m_st == 1) begin
      m_k <= m_k + 1;
      if (m_k == N - 1) begin
        r = ref_op(m_op, m_a, m_b);
        m_res <= r[W-1:0];
        m_c <= r[W];
        m_z <= r[W-1:0] == '0;
        m_e <= m_op == 3'd4 && &r[W-1:0];
        m_st <= 2;
      end
    end else if (resp_ready) begin
      m_st <= 0;
    end
  end

  always @(negedge clk) if (go) begin
    int s;
    chk("req_ready", req_ready, m_st == 0);
    chk("resp_valid", resp_valid, m_st == 2);
    if (m_st != 1) begin
      chk("resp_res", resp_res, m_res);
      chk("resp_carry", resp_carry, m_c);
      chk("resp_zero", resp_zero, m_z);
      chk("resp_eq", resp_eq, m_e);
      chk("alu_idle", {alu_ctrl, alu_d2, alu_d1}, 0);
    end else begin
      s = m_op == 3'd7 ? N - 1 - m_k : m_k;
      chk("alu_d1", alu_d1, m_a[4*s +: 4]);
      chk("alu_d2", alu_d2, m_b[4*s +: 4]);
      chk("alu_ctrl_low", alu_ctrl[3:0], CTRL[m_op]);
      if (m_op == 3'd7) chk("rshft_cin", alu_ctrl[4], s == N - 1 ? 1'b0 : m_b[4*s+4]);
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                       output logic [W-1:0] res, output logic c, output logic z, output logic e, output int lat);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_op = op;
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    @(negedge clk);
    req_op = 3'($urandom);
    req_a = W'($urandom);
    req_b = W'($urandom);
    lat = 1;
    while (!resp_valid && lat < 40) begin
      if (lat <= N) begin
        cap_d2[lat-1] = alu_d2;
        cap_cin[lat-1] = alu_ctrl[4];
      end
      @(negedge clk);
      lat++;
    end
    chk("resp_valid_seen", resp_valid, 1);
    res = resp_res;
    c = resp_carry;
    z = resp_zero;
    e = resp_eq;
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] r;
    logic c, z, e;
    int lat;
    repeat (2) @(negedge clk);
    go = 1;
    req_valid = 1'b1;
    req_a = 16'h1111;
    req_b = 16'h0001;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_flags", {resp_res, resp_carry, resp_zero, resp_eq}, 0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    foreach (dir[i]) begin
      do_op(dir[i].op, dir[i].a, dir[i].b, i == 0 ? 3 : 0, r, c, z, e, lat);
      chk($sformatf("dir%0d_res", i), r, dir[i].res);
      chk($sformatf("dir%0d_carry", i), c, dir[i].c);
      chk($sformatf("dir%0d_zero", i), z, dir[i].z);
      chk($sformatf("dir%0d_eq", i), e, dir[i].e);
      chk($sformatf("dir%0d_latency", i), lat, 5);
      if (dir[i].op == 3'd7) begin
        chk("rshft_d2", {cap_d2[0], cap_d2[1], cap_d2[2], cap_d2[3]}, 16'h8421);
        chk("rshft_cins", {cap_cin[0], cap_cin[1], cap_cin[2], cap_cin[3]}, 0);
      end
    end
    req_op = 3'd0;
    req_a = 16'h1234;
    req_b = 16'h0FFF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_outputs", {resp_res, resp_carry, resp_zero, resp_eq}, 0);
    rst_n = 1'b1;
    req_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_resp", resp_valid, 0);
    end
    repeat (150) begin
      do_op(3'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 3), r, c, z, e, lat);
      chk("rand_latency", lat, 5);
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
